// File: rtl/bp_zynq_cfg_seq_pkg.sv
// Shared types and cfg-bus register map for the zynqparrot boot configuration sequencer.
package bp_zynq_cfg_seq_pkg;

  typedef enum logic [2:0] {
    E_SEQ_IDLE,
    E_SEQ_PROG,
    E_SEQ_VRD,
    E_SEQ_UNFREEZE,
    E_SEQ_DONE
  } seq_state_e;

  typedef enum logic [2:0] {
    E_STEP_FREEZE = 3'd0,
    E_STEP_NPC    = 3'd1,
    E_STEP_ICACHE = 3'd2,
    E_STEP_DCACHE = 3'd3,
    E_STEP_CCE    = 3'd4
  } seq_step_e;

  localparam int unsigned CFG_REG_FREEZE = 'h00008;
  localparam int unsigned CFG_REG_NPC    = 'h00010;
  localparam int unsigned CFG_REG_ICACHE = 'h00220;
  localparam int unsigned CFG_REG_DCACHE = 'h00240;
  localparam int unsigned CFG_REG_CCE    = 'h00280;

endpackage

// File: rtl/bp_zynq_cfg_next_core.sv
// Priority encoder: lowest set mask bit strictly above cur_i, or the lowest set bit overall when first_i.
module bp_zynq_cfg_next_core #(
  parameter int num_core_p  = 1,
  parameter int idx_width_p = 1
) (
  input  logic [num_core_p-1:0]  mask_i,
  input  logic [idx_width_p-1:0] cur_i,
  input  logic                   first_i,
  output logic [idx_width_p-1:0] next_o,
  output logic                   v_o
);

  // Descending scan so the lowest qualifying index is the last one written.
  always_comb begin
    next_o = '0;
    v_o    = 1'b0;
    for (int i = num_core_p - 1; i >= 0; i--) begin
      if (mask_i[i] && (first_i || (i > int'(cur_i)))) begin
        next_o = idx_width_p'(i);
        v_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bp_zynq_cfg_sequencer.sv
// Boot-time cfg-bus sequencer: freeze/npc/mode writes per enabled core, then a common unfreeze pass.
// Optional readback verification enabled by defining BP_ZYNQ_CFG_SEQ_VERIFY_EN.
module bp_zynq_cfg_sequencer
  import bp_zynq_cfg_seq_pkg::*;
#(
  parameter int num_core_p       = 1,
  parameter int core_id_width_p  = 4,
  parameter int cfg_addr_width_p = 20,
  parameter int cfg_data_width_p = 64,
  parameter int vaddr_width_p    = 39
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        start_i,
  input  logic [num_core_p-1:0]       core_mask_i,
  input  logic [vaddr_width_p-1:0]    npc_i,
  input  logic [1:0]                  icache_mode_i,
  input  logic [1:0]                  dcache_mode_i,
  input  logic                        cce_mode_i,
  output logic                        cfg_v_o,
  input  logic                        cfg_ready_i,
  output logic [core_id_width_p-1:0]  cfg_core_id_o,
  output logic [cfg_addr_width_p-1:0] cfg_addr_o,
  output logic [cfg_data_width_p-1:0] cfg_data_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        error_o
`ifdef BP_ZYNQ_CFG_SEQ_VERIFY_EN
  ,
  output logic                        cfg_r_o,
  input  logic                        cfg_resp_v_i,
  input  logic [cfg_data_width_p-1:0] cfg_resp_data_i
`endif
);

  localparam int idx_w = (num_core_p > 1) ? $clog2(num_core_p) : 1;

  seq_state_e                state_q, state_d;
  seq_step_e                 step_q, step_d;
  logic [idx_w-1:0]          core_q, core_d;
  logic [idx_w-1:0]          first_q, first_d;
  logic [num_core_p-1:0]     mask_q, mask_d;
  logic [vaddr_width_p-1:0]  npc_q, npc_d;
  logic [1:0]                icache_q, icache_d;
  logic [1:0]                dcache_q, dcache_d;
  logic                      cce_q, cce_d;

  logic [idx_w-1:0]          first_in, nxt;
  logic                      first_in_v, nxt_v;
  logic                      wr_fire, prog_adv;

  bp_zynq_cfg_next_core #(.num_core_p(num_core_p), .idx_width_p(idx_w)) u_first (
    .mask_i (core_mask_i),
    .cur_i  ('0),
    .first_i(1'b1),
    .next_o (first_in),
    .v_o    (first_in_v)
  );

  bp_zynq_cfg_next_core #(.num_core_p(num_core_p), .idx_width_p(idx_w)) u_next (
    .mask_i (mask_q),
    .cur_i  (core_q),
    .first_i(1'b0),
    .next_o (nxt),
    .v_o    (nxt_v)
  );

  assign cfg_v_o       = (state_q == E_SEQ_PROG) || (state_q == E_SEQ_UNFREEZE);
  assign busy_o        = cfg_v_o || (state_q == E_SEQ_VRD);
  assign done_o        = (state_q == E_SEQ_DONE);
  assign cfg_core_id_o = core_id_width_p'(core_q);
  assign wr_fire       = cfg_v_o && cfg_ready_i;

  always_comb begin
    cfg_addr_o = cfg_addr_width_p'(CFG_REG_FREEZE);
    cfg_data_o = '0;
    if (state_q != E_SEQ_UNFREEZE) begin
      case (step_q)
        E_STEP_FREEZE: cfg_data_o = cfg_data_width_p'(1'b1);
        E_STEP_NPC: begin
          cfg_addr_o = cfg_addr_width_p'(CFG_REG_NPC);
          cfg_data_o = cfg_data_width_p'(npc_q);
        end
        E_STEP_ICACHE: begin
          cfg_addr_o = cfg_addr_width_p'(CFG_REG_ICACHE);
          cfg_data_o = cfg_data_width_p'(icache_q);
        end
        E_STEP_DCACHE: begin
          cfg_addr_o = cfg_addr_width_p'(CFG_REG_DCACHE);
          cfg_data_o = cfg_data_width_p'(dcache_q);
        end
        E_STEP_CCE: begin
          cfg_addr_o = cfg_addr_width_p'(CFG_REG_CCE);
          cfg_data_o = cfg_data_width_p'(cce_q);
        end
        default: ;
      endcase
    end
  end

`ifdef BP_ZYNQ_CFG_SEQ_VERIFY_EN
  logic error_q, error_d;
  logic rd_acc_q, rd_acc_d;
  logic rd_done;

  assign cfg_r_o = (state_q == E_SEQ_VRD) && !rd_acc_q;
  assign error_o = error_q;
  // Response may land in the same cycle the read is accepted.
  assign rd_done = (state_q == E_SEQ_VRD) && cfg_resp_v_i && (rd_acc_q || cfg_ready_i);
  assign prog_adv = rd_done;

  always_comb begin
    error_d  = error_q;
    rd_acc_d = rd_acc_q;
    if ((state_q == E_SEQ_IDLE || state_q == E_SEQ_DONE) && start_i) error_d = 1'b0;
    if (state_q == E_SEQ_PROG && wr_fire) rd_acc_d = 1'b0;
    if (state_q == E_SEQ_VRD && cfg_ready_i) rd_acc_d = 1'b1;
    if (rd_done && (cfg_resp_data_i != cfg_data_o)) error_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      error_q  <= 1'b0;
      rd_acc_q <= 1'b0;
    end else begin
      error_q  <= error_d;
      rd_acc_q <= rd_acc_d;
    end
  end
`else
  assign error_o  = 1'b0;
  assign prog_adv = (state_q == E_SEQ_PROG) && wr_fire;
`endif

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    core_d   = core_q;
    first_d  = first_q;
    mask_d   = mask_q;
    npc_d    = npc_q;
    icache_d = icache_q;
    dcache_d = dcache_q;
    cce_d    = cce_q;

    case (state_q)
      E_SEQ_IDLE, E_SEQ_DONE: begin
        if (start_i) begin
          mask_d   = core_mask_i;
          npc_d    = npc_i;
          icache_d = icache_mode_i;
          dcache_d = dcache_mode_i;
          cce_d    = cce_mode_i;
          step_d   = E_STEP_FREEZE;
          core_d   = first_in;
          first_d  = first_in;
          state_d  = first_in_v ? E_SEQ_PROG : E_SEQ_DONE;
        end
      end
`ifdef BP_ZYNQ_CFG_SEQ_VERIFY_EN
      E_SEQ_PROG: if (wr_fire) state_d = E_SEQ_VRD;
`endif
      E_SEQ_UNFREEZE: begin
        if (wr_fire) begin
          if (nxt_v) core_d = nxt;
          else       state_d = E_SEQ_DONE;
        end
      end
      default: ;
    endcase

    // Core index only moves up to the last enabled core; the unfreeze pass reloads the first one.
    if (prog_adv) begin
      if (step_q == E_STEP_CCE) begin
        step_d = E_STEP_FREEZE;
        if (nxt_v) begin
          core_d  = nxt;
          state_d = E_SEQ_PROG;
        end else begin
          core_d  = first_q;
          state_d = E_SEQ_UNFREEZE;
        end
      end else begin
        step_d  = seq_step_e'(step_q + 3'd1);
        state_d = E_SEQ_PROG;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= E_SEQ_IDLE;
      step_q   <= E_STEP_FREEZE;
      core_q   <= '0;
      first_q  <= '0;
      mask_q   <= '0;
      npc_q    <= '0;
      icache_q <= '0;
      dcache_q <= '0;
      cce_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      core_q   <= core_d;
      first_q  <= first_d;
      mask_q   <= mask_d;
      npc_q    <= npc_d;
      icache_q <= icache_d;
      dcache_q <= dcache_d;
      cce_q    <= cce_d;
    end
  end

endmodule

// File: tb/tb_bp_zynq_cfg_sequencer.sv
// Scoreboard bench for the cfg sequencer: a per-run write list is queued from the sequencing rules, a monitor pops on each accepted write.
module tb_bp_zynq_cfg_sequencer;
  import bp_zynq_cfg_seq_pkg::*;

  localparam int NC = 4;

  logic        clk;
  logic        reset_n_i;
  logic        start_i;
  logic [NC-1:0] core_mask_i;
  logic [38:0] npc_i;
  logic [1:0]  icache_mode_i, dcache_mode_i;
  logic        cce_mode_i;
  logic        cfg_v_o, cfg_ready_i;
  logic [3:0]  cfg_core_id_o;
  logic [19:0] cfg_addr_o;
  logic [63:0] cfg_data_o;
  logic        busy_o, done_o, error_o;
`ifdef BP_ZYNQ_CFG_SEQ_VERIFY_EN
  logic        cfg_r_o;
  logic        cfg_resp_v_i;
  logic [63:0] cfg_resp_data_i;
  assign cfg_resp_v_i    = 1'b1;
  assign cfg_resp_data_i = cfg_data_o;
`endif

  bp_zynq_cfg_sequencer #(
    .num_core_p(NC), .core_id_width_p(4), .cfg_addr_width_p(20),
    .cfg_data_width_p(64), .vaddr_width_p(39)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .start_i(start_i),
    .core_mask_i(core_mask_i), .npc_i(npc_i),
    .icache_mode_i(icache_mode_i), .dcache_mode_i(dcache_mode_i), .cce_mode_i(cce_mode_i),
    .cfg_v_o(cfg_v_o), .cfg_ready_i(cfg_ready_i), .cfg_core_id_o(cfg_core_id_o),
    .cfg_addr_o(cfg_addr_o), .cfg_data_o(cfg_data_o),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
`ifdef BP_ZYNQ_CFG_SEQ_VERIFY_EN
    , .cfg_r_o(cfg_r_o), .cfg_resp_v_i(cfg_resp_v_i), .cfg_resp_data_i(cfg_resp_data_i)
`endif
  );

  typedef struct {
    logic [3:0]  core;
    logic [19:0] addr;
    logic [63:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  int  rmode    = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Ready: 0 = always high, 1 = random, 2 = repeating 0,0,1.
  initial begin
    int pc;
    pc = 0;
    cfg_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0: cfg_ready_i = 1'b1;
        1: cfg_ready_i = 1'($urandom_range(0, 1));
        default: begin
          cfg_ready_i = (pc == 2);
          pc = (pc == 2) ? 0 : pc + 1;
        end
      endcase
    end
  end

  // Monitor: pop on each accepted write, and hold stalled requests to their values.
  initial begin
    bit   pend;
    wr_t  held, got, e;
    pend = 0;
    forever begin
      @(negedge clk);
      if (!reset_n_i) pend = 0;
      else begin
        got.core = cfg_core_id_o;
        got.addr = cfg_addr_o;
        got.data = cfg_data_o;
        if (pend) begin
          chk("stall_v_held", cfg_v_o, 1);
          chk("stall_stable", (got.core == held.core) && (got.addr == held.addr) && (got.data == held.data), 1);
        end
        if (cfg_v_o && cfg_ready_i) begin
          chk("write_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("wr_core", got.core, e.core);
            chk("wr_addr", got.addr, e.addr);
            chk("wr_data", got.data, e.data);
          end
        end
        pend = cfg_v_o && !cfg_ready_i;
        held = got;
      end
    end
  end

  // Reference: each enabled core in ascending order gets freeze, npc, modes; then one unfreeze each.
  task automatic push_model(input logic [NC-1:0] mask, input logic [38:0] npc,
                            input logic [1:0] ic, input logic [1:0] dc, input logic cce);
    logic [19:0] addrs [5];
    logic [63:0] datas [5];
    addrs[0] = 20'(CFG_REG_FREEZE); datas[0] = 64'd1;
    addrs[1] = 20'(CFG_REG_NPC);    datas[1] = 64'(npc);
    addrs[2] = 20'(CFG_REG_ICACHE); datas[2] = 64'(ic);
    addrs[3] = 20'(CFG_REG_DCACHE); datas[3] = 64'(dc);
    addrs[4] = 20'(CFG_REG_CCE);    datas[4] = 64'(cce);
    for (int c = 0; c < NC; c++)
      if (mask[c])
        for (int s = 0; s < 5; s++) exp_q.push_back('{core: 4'(c), addr: addrs[s], data: datas[s]});
    for (int c = 0; c < NC; c++)
      if (mask[c]) exp_q.push_back('{core: 4'(c), addr: 20'(CFG_REG_FREEZE), data: 64'd0});
  endtask

  task automatic run_seq(input logic [NC-1:0] mask, input logic [38:0] npc, input int mode, input bit dbl);
    logic [1:0] ic, dc;
    logic       cce;
    int         k, cyc;
    ic  = 2'($urandom);
    dc  = 2'($urandom);
    cce = 1'($urandom);
    k   = $countones(mask);
    rmode = mode;
    push_model(mask, npc, ic, dc, cce);
    core_mask_i = mask; npc_i = npc;
    icache_mode_i = ic; dcache_mode_i = dc; cce_mode_i = cce;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    cyc = 1;
    chk("busy_after_start", busy_o, (k != 0));
    chk("done_cleared", done_o, (k == 0));
    while (!done_o && cyc < 600) begin
      if (dbl && cyc == 2) begin
        start_i = 1'b1; core_mask_i = ~mask; npc_i = ~npc;
      end else start_i = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    start_i = 1'b0;
    chk("done_rise", done_o, 1);
    chk("busy_at_done", busy_o, 0);
`ifndef BP_ZYNQ_CFG_SEQ_VERIFY_EN
    if (mode == 0) chk("latency", 64'(cyc), 64'(6 * k + 1));
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 0);
    chk("done_held", done_o, 1);
    chk("error_clear", error_o, 0);
  endtask

  initial begin
    reset_n_i = 1'b0; start_i = 1'b0; core_mask_i = '0; npc_i = '0;
    icache_mode_i = '0; dcache_mode_i = '0; cce_mode_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_v", cfg_v_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_error", error_o, 0);
    reset_n_i = 1'b1;
    @(posedge clk); #1;
    chk("idle_v", cfg_v_o, 0);

    run_seq(4'b0001, 39'h0_8000_0000, 0, 0);
    run_seq(4'b1010, 39'($urandom), 0, 0);
    run_seq(4'b0000, 39'($urandom), 0, 0);
    run_seq(4'b1010, 39'($urandom), 2, 0);
    run_seq(4'b1111, 39'($urandom), 2, 1);

    // Reset while core 0 is at its icache-mode write, then replay.
    rmode = 0;
    push_model(4'b0001, 39'h12345, 2'd1, 2'd2, 1'b1);
    core_mask_i = 4'b0001; npc_i = 39'h12345;
    icache_mode_i = 2'd1; dcache_mode_i = 2'd2; cce_mode_i = 1'b1;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    chk("pre_rst_addr", cfg_addr_o, 20'(CFG_REG_ICACHE));
    reset_n_i = 1'b0;
    #1;
    chk("midrst_v", cfg_v_o, 0);
    chk("midrst_busy", busy_o, 0);
    exp_q.delete();
    @(posedge clk); #1;
    reset_n_i = 1'b1;
    @(posedge clk); #1;
    run_seq(4'b0001, 39'h12345, 0, 0);

    for (int r = 0; r < 10; r++)
      run_seq(NC'($urandom), 39'({$urandom, $urandom}), int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bp_zynq_cfg_sequencer.md
Name: bp_zynq_cfg_sequencer

Overview:
Boot-time configuration sequencer that programs the BlackParrot cfg bus of every core in a unicore or multicore zynqparrot build.
- Generalised to num_core_p cores, with a per-core enable mask and a runtime-selectable PC, cache mode and CCE mode.
- Sits between the host-side control CSRs and the processor's cfg bus.
- Writes freeze, PC and mode registers for each core, then releases freeze on all enabled cores together.

Parameters:
num_core_p, 1, number of cores addressed (1..16).
core_id_width_p, 4, width of cfg core-id field (must be >= clog2(num_core_p)).
cfg_addr_width_p, 20, cfg bus register address width.
cfg_data_width_p, 64, cfg bus data width.
vaddr_width_p, 39, width of the boot PC.

Ports:
clk_i  in  1  clock.
reset_n_i  in  1  asynchronous, active-low reset.
start_i  in  1  one-cycle pulse, accepted only in IDLE or DONE.
core_mask_i  in  num_core_p  cores to program; sampled on start.
npc_i  in  vaddr_width_p  boot PC; sampled on start.
icache_mode_i  in  2  icache mode; sampled on start.
dcache_mode_i  in  2  dcache mode; sampled on start.
cce_mode_i  in  1  0=uncached, 1=normal; sampled on start.
cfg_v_o  out  1  cfg write valid.
cfg_ready_i  in  1  cfg write ready.
cfg_core_id_o  out  core_id_width_p  target core.
cfg_addr_o  out  cfg_addr_width_p  register address.
cfg_data_o  out  cfg_data_width_p  write data, zero-extended.
busy_o  out  1  sequence in progress.
done_o  out  1  sequence finished; held until next start.
error_o  out  1  readback mismatch (feature only; otherwise tied 0).

Behaviour:
- Reset (async assert, sync deassert): state=IDLE; cfg_v_o, busy_o, done_o, error_o = 0; all registers cleared.
- States: IDLE -> PROG -> UNFREEZE -> DONE.
- start_i in IDLE/DONE:
  - Latches all inputs; clears done_o and error_o; busy_o=1 next cycle.
  - core_mask all-zero: go straight to DONE (done_o=1 one cycle after start).
- start_i while busy: ignored.
- PROG, for each enabled core in ascending id order, issues 5 writes:
  - freeze=1
  - npc
  - icache_mode
  - dcache_mode
  - cce_mode
  - Disabled cores are skipped with zero idle cycles (priority-encode the next set mask bit).
- UNFREEZE: one write freeze=0 per enabled core, ascending id.
- Handshake:
  - cfg_v_o/addr/data/core_id remain stable until cfg_v_o&cfg_ready_i.
  - Next write is presented in the cycle after acceptance, so back-to-back ready gives 1 write/cycle.
  - cfg_v_o never drops without acceptance.
- Latency: with ready always high and k enabled cores, done_o rises 6k+1 cycles after the start cycle. busy_o falls in the same cycle done_o rises.
- Counters: step counter 0..4 (3 bits) wraps to 0 on core advance; core index saturates at the last enabled core, never wraps.
- Reset mid-sequence returns to IDLE immediately. Partial cfg state in the cores is not undone; the host must restart.
- Register addresses come from package constants. Data fields are zero-extended to cfg_data_width_p.

Optional Feature:
BP_ZYNQ_CFG_SEQ_VERIFY_EN
- Defined:
  - Adds ports cfg_r_o(out,1), cfg_resp_v_i(in,1) and cfg_resp_data_i(in,cfg_data_width_p).
  - After each PROG write, a read of the same address is issued (cfg_r_o=1) and the sequencer waits for cfg_resp_v_i.
  - Mismatch sets error_o (sticky until next start) and continues the sequence.
  - Latency becomes 11k+1 plus response delays.
- Undefined: no extra ports; error_o tied 0.

Decomposition:
- Shared package bp_zynq_cfg_seq_pkg holds:
  - state enum
  - register address localparams: freeze, npc, icache_mode, dcache_mode, cce_mode
  - step enum
- One natural sub-module: bp_zynq_cfg_next_core, a combinational priority encoder finding the next set mask bit above the current index, with found/valid outputs.

Test Plan:
- num_core_p=1, mask=1, npc=0x80000000, ready=1 -> 6 writes: freeze=1, npc=0x80000000, icache_mode, dcache_mode, cce_mode, freeze=0; done_o at cycle 7.
- num_core_p=4, mask=4'b1010 -> PROG writes to core 1 then core 3 (10 writes), then freeze=0 to cores 1 and 3; done_o at cycle 13.
- mask=0 -> no cfg_v_o; done_o=1 one cycle after start.
- cfg_ready_i toggled 0,0,1 repeatedly -> outputs stable while stalled; write order identical to ready=1 run.
- reset_n_i asserted during step 2 of core 0 -> cfg_v_o=0 immediately; a later start replays the full sequence from freeze.
- VERIFY_EN with response data differing on dcache_mode -> error_o=1, sequence completes, done_o=1; next start clears error_o.
